// File: rtl/env_vca.sv
// env_vca: envelope-controlled amplifier with a 2-stage sample pipeline and voice-activity tracking.
// Optional macro ENV_SLEW_EN: env_eff ramps toward the target by at most slew_step per strobe.
module env_vca #(
    parameter int unsigned nbit_data = 6,
    parameter int unsigned nbit_smp  = 12,
    parameter int unsigned slew_step = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [nbit_smp-1:0] smp_in,
    input  logic                       smp_valid,
    input  logic [nbit_data-1:0]       env_in,
    input  logic                       env_vout,
    output logic signed [nbit_smp-1:0] smp_out,
    output logic                       smp_out_valid,
    output logic                       active
);
    localparam int unsigned PW = nbit_smp + nbit_data + 1;
    localparam logic [nbit_data-1:0] EnvMax = '1;
    localparam logic signed [PW-1:0] Half = PW'(2 ** (nbit_data - 1));

    typedef enum logic [1:0] {StIdle, StRun, StTail} state_e;

    state_e                     state_q;
    logic                       active_q;
    logic signed [nbit_smp-1:0] smp_s1_q, smp_s1_d;
    logic signed [nbit_smp-1:0] smp_out_q, smp_out_d;
    logic [nbit_data-1:0]       env_s1_q, env_s1_d;
    logic [nbit_data-1:0]       env_eff_q, env_eff_d;
    logic [nbit_data-1:0]       env_tgt;
    logic                       v1_q, v1_d;
    logic                       vout_q, vout_d;
    logic signed [PW-1:0]       prod, rnd;
    logic                       unused_rnd;

`ifdef ENV_SLEW_EN
    localparam logic [nbit_data-1:0] Step = nbit_data'(slew_step);
`else
    logic unused_slew_step;
    assign unused_slew_step = ^nbit_data'(slew_step);
`endif

    // Stage 1: capture the sample and the effective envelope on strobe cycles only.
    always_comb begin
        env_tgt   = env_vout ? env_in : '0;
        env_eff_d = env_eff_q;
        if (smp_valid) begin
`ifdef ENV_SLEW_EN
            if (env_tgt > env_eff_q) begin
                env_eff_d = (env_tgt - env_eff_q > Step) ? env_eff_q + Step : env_tgt;
            end else if (env_tgt < env_eff_q) begin
                env_eff_d = (env_eff_q - env_tgt > Step) ? env_eff_q - Step : env_tgt;
            end
`else
            env_eff_d = env_tgt;
`endif
        end
        v1_d     = smp_valid;
        smp_s1_d = smp_valid ? smp_in : smp_s1_q;
        env_s1_d = smp_valid ? env_eff_d : env_s1_q;
    end

    // Stage 2: full-scale envelope bypasses the multiply so max level is exact unity gain.
    always_comb begin
        prod      = smp_s1_q * $signed({1'b0, env_s1_q});
        rnd       = prod + Half;
        smp_out_d = smp_out_q;
        if (v1_q) begin
            smp_out_d = (env_s1_q == EnvMax) ? smp_s1_q : rnd[nbit_data +: nbit_smp];
        end
        vout_d = v1_q;
    end

    assign unused_rnd = ^{rnd[PW-1], rnd[nbit_data-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_s1_q  <= '0;
            env_s1_q  <= '0;
            env_eff_q <= '0;
            v1_q      <= 1'b0;
            smp_out_q <= '0;
            vout_q    <= 1'b0;
        end else begin
            smp_s1_q  <= smp_s1_d;
            env_s1_q  <= env_s1_d;
            env_eff_q <= env_eff_d;
            v1_q      <= v1_d;
            smp_out_q <= smp_out_d;
            vout_q    <= vout_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (smp_valid && env_vout) begin
                        state_q  <= StRun;
                        active_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (smp_valid && !env_vout) begin
                        state_q <= StTail;
                    end
                end
                StTail: begin
                    if (smp_valid && env_vout) begin
                        state_q <= StRun;
                    end else if (env_eff_q == '0 && !v1_q && !vout_q) begin
                        state_q  <= StIdle;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign smp_out       = smp_out_q;
    assign smp_out_valid = vout_q;
    assign active        = active_q;

endmodule

// File: tb/tb_env_vca.sv
// Directed bench for env_vca: reset, scaling, latency, back-to-back throughput and voice FSM.
// Build with ENV_SLEW_EN defined to exercise the envelope slew ramp instead of the static tests.
module tb_env_vca;
    logic              clk = 1'b0;
    logic              rst;
    logic signed [11:0] smp_in;
    logic              smp_valid;
    logic [5:0]        env_in;
    logic              env_vout;
    logic signed [11:0] smp_out;
    logic              smp_out_valid;
    logic              active;

    int n_checks = 0;
    int n_errors = 0;
    int seen;

    env_vca #(
        .nbit_data(6),
        .nbit_smp (12),
        .slew_step(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .smp_in       (smp_in),
        .smp_valid    (smp_valid),
        .env_in       (env_in),
        .env_vout     (env_vout),
        .smp_out      (smp_out),
        .smp_out_valid(smp_out_valid),
        .active       (active)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one strobe; returns at the negedge after the capturing posedge.
    task automatic send(input int s, input int e, input bit v);
        smp_in    = 12'(s);
        env_in    = 6'(e);
        env_vout  = v;
        smp_valid = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input int s, input int e, input bit v, input int exp);
        send(s, e, v);
        check({tag, "_lat"}, int'(smp_out_valid), 0);
        @(negedge clk);
        check({tag, "_vld"}, int'(smp_out_valid), 1);
        check(tag, int'(smp_out), exp);
    endtask

    initial begin
        rst       = 1'b1;
        smp_in    = '0;
        smp_valid = 1'b0;
        env_in    = '0;
        env_vout  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", int'(smp_out), 0);
        check("rst_vld", int'(smp_out_valid), 0);
        check("rst_act", int'(active), 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset with two samples in flight
        smp_in = 12'sd500; env_in = 6'd63; env_vout = 1'b1; smp_valid = 1'b1;
        @(negedge clk);
        smp_in = 12'sd600;
        @(negedge clk);
        smp_valid = 1'b0;
        check("flight_out", int'(smp_out), 500);
        check("flight_act", int'(active), 1);
        rst = 1'b1;
        #1;
        check("midrst_out", int'(smp_out), 0);
        check("midrst_vld", int'(smp_out_valid), 0);
        check("midrst_act", int'(active), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (smp_out_valid) seen++;
        end
        check("midrst_nostrobe", seen, 0);

`ifdef ENV_SLEW_EN
        // env_eff ramps 1,2,3,4 -> 640*k/64 rounded half up
        for (int k = 1; k <= 4; k++) begin
            run_one("slew", 640, 63, 1'b1, 10 * k);
        end
        check("slew_act", int'(active), 1);
`else
        run_one("unity_min", -2048, 63, 1'b1, -2048);
        check("unity_act", int'(active), 1);

        run_one("half_1000", 1000, 32, 1'b1, 500);
        @(negedge clk);
        check("hold_out", int'(smp_out), 500);
        check("hold_vld", int'(smp_out_valid), 0);
        run_one("half_m1001", -1001, 32, 1'b1, -500);
        run_one("half_3", 3, 32, 1'b1, 2);
        run_one("zero_env", 2047, 0, 1'b1, 0);

        // Back-to-back strobes at full rate
        smp_in = 12'sd100; env_in = 6'd63; env_vout = 1'b1; smp_valid = 1'b1;
        @(negedge clk);
        smp_in = 12'sd200;
        @(negedge clk);
        check("b2b_v0", int'(smp_out_valid), 1);
        check("b2b_0", int'(smp_out), 100);
        smp_in = 12'sd300;
        @(negedge clk);
        smp_valid = 1'b0;
        check("b2b_v1", int'(smp_out_valid), 1);
        check("b2b_1", int'(smp_out), 200);
        @(negedge clk);
        check("b2b_v2", int'(smp_out_valid), 1);
        check("b2b_2", int'(smp_out), 300);
        @(negedge clk);
        check("b2b_end", int'(smp_out_valid), 0);

        // RUN -> TAIL with one RUN sample still in flight, then drain to IDLE
        smp_in = 12'sd400; env_in = 6'd63; env_vout = 1'b1; smp_valid = 1'b1;
        @(negedge clk);
        smp_in = 12'sd555; env_vout = 1'b0;
        @(negedge clk);
        smp_valid = 1'b0;
        check("tail_out0", int'(smp_out), 400);
        check("tail_act0", int'(active), 1);
        @(negedge clk);
        check("tail_vld1", int'(smp_out_valid), 1);
        check("tail_out1", int'(smp_out), 0);
        check("tail_act1", int'(active), 1);
        @(negedge clk);
        check("tail_vld2", int'(smp_out_valid), 0);
        check("tail_act2", int'(active), 1);
        @(negedge clk);
        check("tail_idle", int'(active), 0);

        // IDLE still emits zero samples with strobes
        run_one("idle_smp", 777, 40, 1'b0, 0);
        check("idle_act", int'(active), 0);

        // TAIL -> RUN with a zero envelope: RUN must not drain back to IDLE
        send(100, 63, 1'b1);
        send(100, 63, 1'b0);
        send(300, 0, 1'b1);
        repeat (6) @(negedge clk);
        check("tail_to_run_act", int'(active), 1);
        check("tail_to_run_out", int'(smp_out), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
